// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin front end sharing one sequential divider among four clients
module div_arbiter #(
    parameter int nBit = 16,
    parameter int TMO  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        req,
    input  logic [4*nBit-1:0] A_in,
    input  logic [4*nBit-1:0] B_in,
    output logic [3:0]        gnt,
    output logic [3:0]        resp_valid,
    output logic [nBit-1:0]   R_out,
    output logic [nBit-1:0]   Q_out,
    output logic              dbz,
    output logic              err,
    output logic              busy,
    output logic [nBit-1:0]   div_A,
    output logic [nBit-1:0]   div_B,
    output logic              div_start,
    input  logic              div_done,
    input  logic [nBit-1:0]   div_R,
    input  logic [nBit-1:0]   div_Q
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      last_q, last_d;
    logic [1:0]      owner_q, owner_d;
    logic [nBit-1:0] a_q, a_d, b_q, b_d;
    logic [nBit-1:0] r_q, r_d, q_q, q_d;
    logic            dbz_q, dbz_d, err_q, err_d;
    logic [7:0]      cnt_q, cnt_d;

    logic [1:0]      start, pos, win;
    logic [7:0]      rot;
    logic            any_req, tmo_hit;
    logic [nBit-1:0] a_win, b_win;

    // Rotate the request vector so the search always begins just after the last owner.
    assign start   = last_q + 2'd1;
    assign rot     = {req, req} >> start;
    assign any_req = |req;
    assign win     = start + pos;
    assign tmo_hit = ({1'b0, cnt_q} + 9'd2) >= 9'(TMO);

    always_comb begin
        pos = 2'd3;
        if (rot[0])      pos = 2'd0;
        else if (rot[1]) pos = 2'd1;
        else if (rot[2]) pos = 2'd2;
    end

    always_comb begin
        a_win = '0;
        b_win = '0;
        for (int i = 0; i < 4; i++) begin
            if (win == 2'(i)) begin
                a_win = A_in[i*nBit +: nBit];
                b_win = B_in[i*nBit +: nBit];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        a_d        = a_q;
        b_d        = b_q;
        r_d        = r_q;
        q_d        = q_q;
        dbz_d      = dbz_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
        gnt        = 4'b0000;
        resp_valid = 4'b0000;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt     = 4'b0001 << win;
                    owner_d = win;
                    a_d     = a_win;
                    b_d     = b_win;
                    if (b_win == '0) begin
                        // Divide-by-zero answers straight away without touching the core.
                        r_d     = a_win;
                        q_d     = '1;
                        dbz_d   = 1'b1;
                        err_d   = 1'b0;
                        state_d = RESP;
                    end else begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                cnt_d   = 8'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (div_done) begin
                    r_d     = div_R;
                    q_d     = div_Q;
                    dbz_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (tmo_hit) begin
                    r_d     = '0;
                    q_d     = '0;
                    dbz_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                resp_valid = 4'b0001 << owner_q;
                last_d     = owner_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 2'd3;
            owner_q <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dbz_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dbz_q   <= dbz_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign div_start = (state_q == LAUNCH);
    assign div_A     = a_q;
    assign div_B     = b_q;
    assign R_out     = r_q;
    assign Q_out     = q_q;
    assign dbz       = dbz_q;
    assign err       = err_q;

endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - randomized bench for div_arbiter against a transaction-level timing model
module tb_div_arbiter;

    localparam int NB  = 16;
    localparam int TMO = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [3:0]      req = 4'b0;
    logic [4*NB-1:0] A_in = '0;
    logic [4*NB-1:0] B_in = '0;
    logic [3:0]      gnt, resp_valid;
    logic [NB-1:0]   R_out, Q_out, div_A, div_B;
    logic            dbz, err, busy, div_start;
    logic            div_done = 1'b0;
    logic [NB-1:0]   div_R = '0;
    logic [NB-1:0]   div_Q = '0;

    div_arbiter #(.nBit(NB), .TMO(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .A_in(A_in), .B_in(B_in),
        .gnt(gnt), .resp_valid(resp_valid), .R_out(R_out), .Q_out(Q_out),
        .dbz(dbz), .err(err), .busy(busy), .div_A(div_A), .div_B(div_B),
        .div_start(div_start), .div_done(div_done), .div_R(div_R), .div_Q(div_Q)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // stimulus knobs; lat_sel: -1 random, 0 core never answers, >0 fixed core latency
    logic [3:0]    pend = 4'b0;
    bit            rand_req = 0, rand_ops = 0, hold_all = 0, spur_en = 0;
    int            lat_sel = 3;
    logic [NB-1:0] op_a [4];
    logic [NB-1:0] op_b [4];

    // reference model: one transaction described by its key cycle numbers
    bit            m_busy = 0;
    int            m_last = 3, m_owner = 0, m_gcyc = 0;
    int            m_start = -1, m_done_cyc = -1, m_resp_cyc = 0;
    logic [NB-1:0] m_a = '0, m_b = '0, m_R = '0, m_Q = '0;
    logic          m_dbz = 0, m_err = 0;

    int            gnt_cnt = 0, resp_cnt = 0, start_cnt = 0;
    int            obs_gnt_cyc = 0, obs_resp_cyc = 0;
    int            gnt_log[$];
    logic [NB-1:0] obs_R = '0, obs_Q = '0;
    logic          obs_dbz = 0, obs_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset_state();
        check_eq("rst_gnt",   32'(gnt), 0);
        check_eq("rst_resp",  32'(resp_valid), 0);
        check_eq("rst_start", 32'(div_start), 0);
        check_eq("rst_busy",  32'(busy), 0);
        check_eq("rst_dbz",   32'(dbz), 0);
        check_eq("rst_err",   32'(err), 0);
        check_eq("rst_R",     32'(R_out), 0);
        check_eq("rst_Q",     32'(Q_out), 0);
        check_eq("rst_divA",  32'(div_A), 0);
        check_eq("rst_divB",  32'(div_B), 0);
    endtask

    task automatic do_reset(input bit spur_done);
        @(posedge clk); #1;
        reset = 1'b0; req = 4'b0; div_done = 1'b0; pend = 4'b0;
        @(posedge clk); #1;
        reset = 1'b1; req = 4'b0; div_done = spur_done;
        m_busy = 0; m_last = 3;
        @(negedge clk);
        check_reset_state();
    endtask

    task automatic step();
        logic [3:0] e_gnt, e_resp;
        int w, lat;
        @(posedge clk); #1;
        cyc++;
        if (m_busy && cyc > m_resp_cyc) begin
            m_busy = 0;
            m_last = m_owner;
        end
        if (rand_req) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(2) == 0) pend[i] = 1'b1;
                else if (pend[i] && $urandom_range(24) == 0) pend[i] = 1'b0;
            end
        end
        if (hold_all) pend = 4'hF;
        req = pend;
        for (int i = 0; i < 4; i++) begin
            A_in[i*NB +: NB] = rand_ops ? 16'($urandom) : op_a[i];
            B_in[i*NB +: NB] = rand_ops ? (($urandom_range(5) == 0) ? 16'h0 : 16'($urandom)) : op_b[i];
        end
        div_done = 1'b0;
        div_R = 16'($urandom);
        div_Q = 16'($urandom);
        if (m_busy && cyc == m_done_cyc) begin
            div_done = 1'b1;
            div_R = m_a % m_b;
            div_Q = m_a / m_b;
        end else if (!m_busy && spur_en && $urandom_range(5) == 0) begin
            div_done = 1'b1;
        end
        e_gnt = 4'b0;
        if (!m_busy && req != 4'b0) begin
            w = -1;
            for (int k = 1; k <= 4; k++)
                if (w < 0 && req[(m_last + k) % 4]) w = (m_last + k) % 4;
            e_gnt[w] = 1'b1;
            m_busy = 1; m_owner = w; m_gcyc = cyc;
            m_a = A_in[w*NB +: NB];
            m_b = B_in[w*NB +: NB];
            m_dbz = 0;
            if (m_b == 0) begin
                m_start = -1; m_done_cyc = -1; m_resp_cyc = cyc + 1;
                m_R = m_a; m_Q = '1; m_dbz = 1; m_err = 0;
            end else begin
                if (lat_sel >= 0) lat = lat_sel;
                else begin
                    case ($urandom_range(11))
                        0:       lat = TMO - 1;
                        1:       lat = 0;
                        default: lat = 1 + $urandom_range(5);
                    endcase
                end
                m_start = cyc + 1;
                if (lat > 0 && lat <= TMO - 1) begin
                    m_done_cyc = cyc + 1 + lat; m_resp_cyc = m_done_cyc + 1;
                    m_R = m_a % m_b; m_Q = m_a / m_b; m_err = 0;
                end else begin
                    m_done_cyc = -1; m_resp_cyc = cyc + TMO + 1;
                    m_R = '0; m_Q = '0; m_err = 1;
                end
            end
        end
        e_resp = (m_busy && cyc == m_resp_cyc) ? (4'b0001 << m_owner) : 4'b0;
        @(negedge clk);
        check_eq("gnt",        32'(gnt), 32'(e_gnt));
        check_eq("resp_valid", 32'(resp_valid), 32'(e_resp));
        check_eq("div_start",  32'(div_start), 32'(m_busy && cyc == m_start));
        check_eq("busy",       32'(busy), 32'(m_busy && cyc > m_gcyc));
        if (e_resp != 4'b0) begin
            check_eq("R_out", 32'(R_out), 32'(m_R));
            check_eq("Q_out", 32'(Q_out), 32'(m_Q));
            check_eq("dbz",   32'(dbz), 32'(m_dbz));
            check_eq("err",   32'(err), 32'(m_err));
        end
        if (m_busy && m_b != 0 && cyc > m_gcyc && cyc < m_resp_cyc) begin
            check_eq("div_A", 32'(div_A), 32'(m_a));
            check_eq("div_B", 32'(div_B), 32'(m_b));
        end
        if (gnt != 4'b0) begin
            gnt_cnt++;
            obs_gnt_cyc = cyc;
            for (int i = 0; i < 4; i++) if (gnt[i]) gnt_log.push_back(i);
        end
        if (resp_valid != 4'b0) begin
            resp_cnt++;
            obs_resp_cyc = cyc;
            obs_R = R_out; obs_Q = Q_out; obs_dbz = dbz; obs_err = err;
        end
        if (div_start) start_cnt++;
        pend = pend & ~e_gnt;
    endtask

    task automatic run_until_grant();
        int g0 = gnt_cnt;
        int n = 0;
        while (gnt_cnt == g0 && n < 400) begin step(); n++; end
        check_eq("grant_seen", 32'(gnt_cnt > g0), 1);
    endtask

    task automatic run_until_resp();
        int r0 = resp_cnt;
        int n = 0;
        while (resp_cnt == r0 && n < 400) begin step(); n++; end
        check_eq("resp_seen", 32'(resp_cnt > r0), 1);
    endtask

    initial begin
        int g, s, r0;
        for (int i = 0; i < 4; i++) begin op_a[i] = 16'd50; op_b[i] = 16'd5; end
        do_reset(1'b0);

        // fairness: everyone requesting continuously
        hold_all = 1; rand_ops = 1; lat_sel = 3;
        gnt_log.delete();
        for (int k = 0; k < 5; k++) run_until_grant();
        hold_all = 0;
        check_eq("rr_len", 32'(gnt_log.size()), 5);
        for (int k = 0; k < 5 && k < gnt_log.size(); k++) check_eq("rr_order", 32'(gnt_log[k]), 32'(k % 4));
        pend = 4'b0010;
        run_until_grant();
        check_eq("rr_owner1", 32'(gnt_log[$]), 1);
        pend = 4'b1010;
        run_until_grant();
        check_eq("rr_skip_to3", 32'(gnt_log[$]), 3);

        // single op 100/7
        rand_ops = 0; op_a[0] = 16'd100; op_b[0] = 16'd7; lat_sel = 4; pend = 4'b0001;
        run_until_grant();
        g = obs_gnt_cyc;
        run_until_resp();
        check_eq("single_Q", 32'(obs_Q), 14);
        check_eq("single_R", 32'(obs_R), 2);
        check_eq("single_flags", 32'({obs_dbz, obs_err}), 0);
        check_eq("single_lat", 32'(obs_resp_cyc - g), 6);

        // divide by zero
        op_a[2] = 16'h1234; op_b[2] = 16'h0; pend = 4'b0100;
        run_until_grant();
        g = obs_gnt_cyc; s = start_cnt;
        run_until_resp();
        check_eq("dbz_Q", 32'(obs_Q), 32'h0000FFFF);
        check_eq("dbz_R", 32'(obs_R), 32'h1234);
        check_eq("dbz_flag", 32'(obs_dbz), 1);
        check_eq("dbz_lat", 32'(obs_resp_cyc - g), 1);
        check_eq("dbz_nostart", 32'(start_cnt - s), 0);

        // core never answers
        op_a[0] = 16'd500; op_b[0] = 16'd3; lat_sel = 0; pend = 4'b0001;
        run_until_grant();
        g = obs_gnt_cyc;
        run_until_resp();
        check_eq("tmo_err", 32'(obs_err), 1);
        check_eq("tmo_RQ", 32'({obs_R, obs_Q}), 0);
        check_eq("tmo_lat", 32'(obs_resp_cyc - g), 32'(TMO + 1));

        // done coincident with expiry
        lat_sel = TMO - 1; pend = 4'b0001;
        run_until_grant();
        g = obs_gnt_cyc;
        run_until_resp();
        check_eq("coin_err", 32'(obs_err), 0);
        check_eq("coin_Q", 32'(obs_Q), 166);
        check_eq("coin_R", 32'(obs_R), 2);
        check_eq("coin_lat", 32'(obs_resp_cyc - g), 32'(TMO + 1));

        // randomized traffic with operand churn and stray done pulses
        rand_req = 1; rand_ops = 1; spur_en = 1; lat_sel = -1;
        repeat (3000) step();
        rand_req = 0; spur_en = 0; pend = 4'b0;
        repeat (TMO + 5) step();

        // reset while waiting on the core
        rand_ops = 0; op_a[0] = 16'd77; op_b[0] = 16'd7; lat_sel = 0; pend = 4'b0001;
        run_until_grant();
        repeat (5) step();
        check_eq("pre_rst_busy", 32'(busy), 1);
        r0 = resp_cnt;
        do_reset(1'b1);
        repeat (3) step();
        check_eq("rst_no_resp", 32'(resp_cnt - r0), 0);
        pend = 4'hF; lat_sel = 2;
        run_until_grant();
        check_eq("rst_first_gnt", 32'(gnt_log[$]), 0);
        pend = 4'b0;
        repeat (8) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
